// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - register-mapped multiplexed 7-segment hex display scanner with PWM dimming
// Optional leading-zero blanking is built when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_ctrl #(
  parameter int NDIG     = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     addr,
  input  logic            wen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NDIG-1:0] dig_en,
  output logic [7:0]      seg
);
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIVW = $clog2(SCAN_DIV);

  localparam logic [11:0] ADDR_DATA   = 12'h000;
  localparam logic [11:0] ADDR_CTRL   = 12'h004;
  localparam logic [11:0] ADDR_BRIGHT = 12'h008;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

  logic [31:0]     data_q, data_d;
  logic [7:0]      blank_q, blank_d;
  logic [7:0]      dp_q, dp_d;
  logic            en_q, en_d;
  logic            lzb_d;
  logic [3:0]      duty_q, duty_d;
  logic [31:0]     rdata_d;

  logic [DIVW-1:0] div;
  logic [IDXW-1:0] idx;
  logic [3:0]      pwm;

  logic [NDIG-1:0] lz_blank;
  logic [3:0]      cur_nib;
  logic [6:0]      glyph;
  logic            lit;
  logic [NDIG-1:0] dig_en_d;
  logic [7:0]      seg_d;

  logic            unused_addr_hi;
  assign unused_addr_hi = ^addr[31:12];

  logic sel_ctrl;
  assign sel_ctrl = wen && (addr[11:0] == ADDR_CTRL);

  // Read mux sees post-write values so a same-cycle write reads back new data.
  always_comb begin
    data_d  = data_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    en_d    = en_q;
    duty_d  = duty_q;
    if (wen) begin
      case (addr[11:0])
        ADDR_DATA:   data_d = wdata;
        ADDR_CTRL: begin
          blank_d = wdata[7:0];
          dp_d    = wdata[15:8];
          en_d    = wdata[16];
        end
        ADDR_BRIGHT: duty_d = wdata[3:0];
        default: ;
      endcase
    end
    case (addr[11:0])
      ADDR_DATA:   rdata_d = data_d;
      ADDR_CTRL:   rdata_d = {14'd0, lzb_d, en_d, dp_d, blank_d};
      ADDR_BRIGHT: rdata_d = {28'd0, duty_d};
      default:     rdata_d = 32'd0;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [31:0] DISP_MASK = (NDIG >= 8) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << (4 * NDIG)) - 64'd1);
  logic        lzb_q;
  logic [31:0] disp_data;

  assign lzb_d     = sel_ctrl ? wdata[17] : lzb_q;
  assign disp_data = data_q & DISP_MASK;

  always_ff @(posedge clk) begin
    if (rst) lzb_q <= 1'b0;
    else     lzb_q <= lzb_d;
  end

  // Digit i is a leading zero when it and every displayed nibble above it are 0.
  always_comb begin
    lz_blank = '0;
    for (int i = 1; i < NDIG; i++) begin
      lz_blank[i] = lzb_q && ((disp_data >> (4 * i)) == 32'd0);
    end
  end
`else
  assign lzb_d    = 1'b0;
  assign lz_blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 32'd0;
      blank_q <= 8'd0;
      dp_q    <= 8'd0;
      en_q    <= 1'b1;
      duty_q  <= 4'hF;
      rdata   <= 32'd0;
    end else begin
      data_q  <= data_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      duty_q  <= duty_d;
      rdata   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      pwm <= pwm + 4'd1;
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
      end else begin
        div <= div + DIVW'(1);
      end
    end
  end

  assign cur_nib = data_q[{idx, 2'b00} +: 4];

  always_comb begin
    case (cur_nib)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  end

  // The first two cycles of every slot stay dark to avoid ghosting between digits.
  always_comb begin
    lit = en_q && !blank_q[idx] && !lz_blank[idx] && (pwm <= duty_q) && (div >= DIVW'(2));
    dig_en_d = '1;
    seg_d    = 8'hFF;
    if (lit) begin
      dig_en_d[idx] = 1'b0;
      seg_d         = {glyph, ~dp_q[idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en <= '1;
      seg    <= 8'hFF;
    end else begin
      dig_en <= dig_en_d;
      seg    <= seg_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl (NDIG=8, SCAN_DIV=16)
module tb_seg7_scan_ctrl;
  localparam int NDIG     = 8;
  localparam int SCAN_DIV = 16;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [31:0] CTRL_ALL = 32'h0003_FFFF;
  localparam logic [31:0] CTRL_LZB = 32'h0003_0000;
`else
  localparam logic [31:0] CTRL_ALL = 32'h0001_FFFF;
  localparam logic [31:0] CTRL_LZB = 32'h0001_0000;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     addr;
  logic            wen;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [NDIG-1:0] dig_en;
  logic [7:0]      seg;

  seg7_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
    .rdata(rdata), .dig_en(dig_en), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] dig; logic [7:0] seg; logic [31:0] rd; } exp_t;
  typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rd; } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   total = 0;
  int   bad = 0;

  int          m_div, m_idx, m_pwm;
  logic [31:0] m_data;
  logic [7:0]  m_blank, m_dp;
  logic        m_en, m_lzb;
  logic [3:0]  m_duty;
  logic [6:0]  glyph_tab [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: predict the edge's outputs from pre-edge state, then advance.
  task automatic step();
    exp_t e, got;
    logic lit;
    logic [3:0] nib;
    if (rst) begin
      e.dig = 8'hFF; e.seg = 8'hFF; e.rd = 32'd0;
      m_div = 0; m_idx = 0; m_pwm = 0;
      m_data = 32'd0; m_blank = 8'd0; m_dp = 8'd0; m_en = 1'b1; m_lzb = 1'b0; m_duty = 4'hF;
    end else begin
      nib = 4'(m_data >> (4 * m_idx));
      lit = m_en && !m_blank[m_idx]
            && !(m_lzb && m_idx > 0 && (m_data >> (4 * m_idx)) == 32'd0)
            && (m_pwm <= int'(m_duty)) && (m_div >= 2);
      e.dig = lit ? ~(8'd1 << m_idx) : 8'hFF;
      e.seg = lit ? {glyph_tab[nib], ~m_dp[m_idx]} : 8'hFF;
      if (wen) begin
        case (addr[11:0])
          12'h000: m_data = wdata;
          12'h004: begin
            m_blank = wdata[7:0]; m_dp = wdata[15:8]; m_en = wdata[16];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            m_lzb = wdata[17];
`endif
          end
          12'h008: m_duty = wdata[3:0];
          default: ;
        endcase
      end
      case (addr[11:0])
        12'h000: e.rd = m_data;
        12'h004: e.rd = {14'd0, m_lzb, m_en, m_dp, m_blank};
        12'h008: e.rd = {28'd0, m_duty};
        default: e.rd = 32'd0;
      endcase
      m_pwm = (m_pwm + 1) % 16;
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % NDIG;
      end else begin
        m_div++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("dig_en", {24'd0, dig_en}, {24'd0, got.dig});
    chk("seg", {24'd0, seg}, {24'd0, got.seg});
    chk("rdata", rdata, got.rd);
  endtask

  task automatic wait_dig(input logic [7:0] want, input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (dig_en !== want && n < 300);
    chk({nm, "_reached"}, {24'd0, dig_en}, {24'd0, want});
  endtask

  initial begin
    int dark, badlit, cnt;
    int lit_n [8];
    logic [7:0] seg_seen [8];
    logic [7:0] exp_dig;

    glyph_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hCAFE_0001, 32'hCAFE_0001};
    vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_0001};
    vecs[2]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, CTRL_ALL};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'hFFFF_FFF5, 32'h5};
    vecs[4]  = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_0001};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         CTRL_ALL};
    vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h5};
    vecs[8]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 32'hFFFF_F000, 32'h1234_5678, 32'h1234_5678};
    vecs[10] = '{1'b0, 32'h5A5A_5008, 32'h0,         32'h5};
    vecs[11] = '{1'b1, 32'h0000_0004, 32'h0001_0000, 32'h0001_0000};
    vecs[12] = '{1'b0, 32'h0000_0002, 32'h0,         32'h0};

    rst = 1'b1; wen = 1'b0; addr = 32'd0; wdata = 32'd0;
    step();
    step();
    chk("rst_dig_en", {24'd0, dig_en}, 32'hFF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    dark = 0; badlit = 0;
    for (int s = 0; s < 128; s++) begin
      step();
      if (dig_en === 8'hFF) dark++;
      else if (seg !== 8'h03) badlit++;
      if (s % 16 == 2) chk("slot_order", {24'd0, dig_en}, {24'd0, ~(8'd1 << (s / 16))});
    end
    chk("guard_cycles", dark, 16);
    chk("seg_zero_lit", badlit, 0);

    wen = 1'b1; addr = 32'h000; wdata = 32'h1234_ABCD; step();
    addr = 32'h004; wdata = 32'h0001_0100; step();
    wen = 1'b0; addr = 32'h000; step();
    chk("rd_data", rdata, 32'h1234_ABCD);
    wait_dig(8'hFE, "dig0");
    chk("dig0_seg", {24'd0, seg}, 32'h84);
    wait_dig(8'h7F, "dig7");
    chk("dig7_seg", {24'd0, seg}, 32'h9F);

    // With SCAN_DIV=16 pwm tracks div, so duty 3 lights div 2..3 only.
    wen = 1'b1; addr = 32'h008; wdata = 32'd3; step();
    wen = 1'b0; step();
    cnt = 0;
    for (int s = 0; s < 256; s++) begin
      step();
      if (dig_en !== 8'hFF) cnt++;
    end
    chk("duty3_on", cnt, 32);
    wen = 1'b1; wdata = 32'd0; step();
    wen = 1'b0; step();
    cnt = 0;
    for (int s = 0; s < 256; s++) begin
      step();
      if (dig_en !== 8'hFF) cnt++;
    end
    chk("duty0_on", cnt, 0);
    wen = 1'b1; wdata = 32'hF; step();
    wen = 1'b0;

    wait_dig(8'hFE, "dig0_again");
    wen = 1'b1; addr = 32'h004; wdata = 32'd0; step();
    wen = 1'b0;
    step();
    chk("en0_dig_en", {24'd0, dig_en}, 32'hFF);
    chk("en0_seg", {24'd0, seg}, 32'hFF);
    wen = 1'b1; wdata = 32'h0001_0000; step();
    wen = 1'b0;

    wait_dig(8'hF7, "dig3");
    rst = 1'b1; step();
    rst = 1'b0;
    for (int s = 0; s < 19; s++) begin
      step();
      exp_dig = (s < 2) ? 8'hFF : (s < 16) ? 8'hFE : (s < 18) ? 8'hFF : 8'hFD;
      chk("post_rst_slot", {24'd0, dig_en}, {24'd0, exp_dig});
    end

    wen = 1'b1; addr = 32'h000; wdata = 32'h0000_00F0; step();
    addr = 32'h004; wdata = 32'h0003_0000; step();
    wen = 1'b0; step();
    chk("ctrl_lzb_rd", rdata, CTRL_LZB);
    for (int k = 0; k < 8; k++) begin
      lit_n[k] = 0;
      seg_seen[k] = 8'h00;
    end
    for (int s = 0; s < 160; s++) begin
      step();
      for (int k = 0; k < 8; k++) begin
        if (dig_en[k] === 1'b0) begin
          lit_n[k]++;
          seg_seen[k] = seg;
        end
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int k = 2; k < 8; k++) chk($sformatf("lzb_dark%0d", k), lit_n[k], 0);
`else
    for (int k = 2; k < 8; k++) begin
      chk($sformatf("nolzb_lit%0d", k), {31'd0, lit_n[k] > 0}, 32'd1);
      chk($sformatf("nolzb_seg%0d", k), {24'd0, seg_seen[k]}, 32'h03);
    end
`endif
    chk("lzb_dig1_seg", {24'd0, seg_seen[1]}, 32'h71);
    chk("lzb_dig0_seg", {24'd0, seg_seen[0]}, 32'h03);

    for (int i = 0; i < 13; i++) begin
      wen = vecs[i].wen; addr = vecs[i].addr; wdata = vecs[i].wdata;
      step();
      chk($sformatf("vec%0d_rd", i), rdata, vecs[i].rd);
    end
    wen = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
